// File: rtl/tsmc16_pad_bank_output_seq.sv
// Bank of TSMC16 output pads with per-pad OE and a group-sequenced attribute
// update engine that spreads drive/pull changes over time to limit SSN.

package core_v_mini_mcu_pkg;
  typedef enum logic [1:0] {TOP, RIGHT, BOTTOM, LEFT} pad_side_e;
endpackage

module PDDWUWSWCDGS_H (
  input  logic I,
  input  logic OEN,
  input  logic RTE,
  input  logic DS0,
  input  logic DS1,
  input  logic DS2,
  input  logic DS3,
  input  logic IE,
  input  logic ST,
  input  logic PU,
  input  logic PD,
  output logic C,
  inout  wire  PAD
);
  assign PAD = OEN ? 1'bz : I;
  assign C   = IE & PAD;
  wire unused_cfg = &{1'b0, RTE, DS0, DS1, DS2, DS3, ST, PU, PD};
endmodule

module PDDWUWSWCDGS_V (
  input  logic I,
  input  logic OEN,
  input  logic RTE,
  input  logic DS0,
  input  logic DS1,
  input  logic DS2,
  input  logic DS3,
  input  logic IE,
  input  logic ST,
  input  logic PU,
  input  logic PD,
  output logic C,
  inout  wire  PAD
);
  assign PAD = OEN ? 1'bz : I;
  assign C   = IE & PAD;
  wire unused_cfg = &{1'b0, RTE, DS0, DS1, DS2, DS3, ST, PU, PD};
endmodule

module tsmc16_pad_bank_output_seq #(
  parameter int unsigned                     NUM_PADS      = 8,
  parameter int unsigned                     PADATTR       = 16,
  parameter int unsigned                     GROUP_SIZE    = 2,
  parameter int unsigned                     SETTLE_CYCLES = 4,
  parameter logic [PADATTR-1:0]              RESET_ATTR    = 'h0034,
  parameter core_v_mini_mcu_pkg::pad_side_e  SIDE          = core_v_mini_mcu_pkg::TOP
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_PADS-1:0]           pad_in_i,
  input  logic [NUM_PADS-1:0]           pad_oe_i,
  output logic [NUM_PADS-1:0]           pad_out_o,
  inout  wire  [NUM_PADS-1:0]           pad_io,
  input  logic                          attr_valid_i,
  output logic                          attr_ready_o,
  input  logic [PADATTR-1:0]            attr_i,
  input  logic [NUM_PADS-1:0]           attr_mask_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [NUM_PADS*PADATTR-1:0]   attr_o
);

  localparam int unsigned NUM_GROUPS = (NUM_PADS + GROUP_SIZE - 1) / GROUP_SIZE;
  localparam int unsigned GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [7:0]  S_LAST     = 8'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, APPLY, SETTLE, DONE} state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        g_q, g_d;
  logic [7:0]           s_q, s_d;
  logic [PADATTR-1:0]   attr_cap_q;
  logic [NUM_PADS-1:0]  mask_q;
  logic [PADATTR-1:0]   attr_q [NUM_PADS];
  logic [NUM_PADS-1:0]  grp_wr;
  logic                 grp_active, last_g, capture, load;
  state_e               step_state;
  logic [GW-1:0]        step_g;

  // Pads of the current group that the captured mask selects.
  always_comb begin
    grp_wr = '0;
    for (int k = 0; k < int'(NUM_PADS); k++)
      grp_wr[k] = mask_q[k] && ((k / int'(GROUP_SIZE)) == int'(g_q));
  end

  assign grp_active = |grp_wr;
  assign last_g     = (g_q == GW'(NUM_GROUPS - 1));
  assign step_state = last_g ? DONE : APPLY;
  assign step_g     = last_g ? g_q : g_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    s_d          = s_q;
    capture      = 1'b0;
    load         = 1'b0;
    attr_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      IDLE: begin
        attr_ready_o = 1'b1;
        if (attr_valid_i) begin
          capture = 1'b1;
          g_d     = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        busy_o = 1'b1;
        if (grp_active && (SETTLE_CYCLES > 0)) begin
          load    = 1'b1;
          s_d     = '0;
          state_d = SETTLE;
        end else begin
          load    = grp_active;
          g_d     = step_g;
          state_d = step_state;
        end
      end
      SETTLE: begin
        busy_o = 1'b1;
        s_d    = s_q + 8'd1;
        if (s_q == S_LAST) begin
          g_d     = step_g;
          state_d = step_state;
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      g_q        <= '0;
      s_q        <= '0;
      attr_cap_q <= RESET_ATTR;
      mask_q     <= '0;
      for (int k = 0; k < int'(NUM_PADS); k++) attr_q[k] <= RESET_ATTR;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      s_q     <= s_d;
      if (capture) begin
        attr_cap_q <= attr_i;
        mask_q     <= attr_mask_i;
      end
      for (int k = 0; k < int'(NUM_PADS); k++)
        if (load && grp_wr[k]) attr_q[k] <= attr_cap_q;
    end
  end

  // Bits above [7] are software-visible only; the pad cell has no pins for them.
  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    assign attr_o[k*PADATTR +: PADATTR] = attr_q[k];
    if (SIDE == core_v_mini_mcu_pkg::TOP || SIDE == core_v_mini_mcu_pkg::BOTTOM) begin : g_h
      PDDWUWSWCDGS_H u_pad (
        .I(pad_in_i[k]), .OEN(~pad_oe_i[k]), .RTE(1'b0),
        .DS0(attr_q[k][4]), .DS1(attr_q[k][5]), .DS2(attr_q[k][6]), .DS3(attr_q[k][7]),
        .IE(attr_q[k][2]), .ST(attr_q[k][3]), .PU(attr_q[k][0]), .PD(attr_q[k][1]),
        .C(pad_out_o[k]), .PAD(pad_io[k])
      );
    end else begin : g_v
      PDDWUWSWCDGS_V u_pad (
        .I(pad_in_i[k]), .OEN(~pad_oe_i[k]), .RTE(1'b0),
        .DS0(attr_q[k][4]), .DS1(attr_q[k][5]), .DS2(attr_q[k][6]), .DS3(attr_q[k][7]),
        .IE(attr_q[k][2]), .ST(attr_q[k][3]), .PU(attr_q[k][0]), .PD(attr_q[k][1]),
        .C(pad_out_o[k]), .PAD(pad_io[k])
      );
    end
  end

endmodule

// File: tb/tb_tsmc16_pad_bank_output_seq.sv
// Directed bench for the pad bank: reset, pad data path, sequenced attribute
// updates (full, sparse, partial group, back-to-back) and mid-sequence reset.

module tb_tsmc16_pad_bank_output_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   pad_in = '0, pad_oe = '0, mask = '0;
  logic [15:0]  attr = '0;
  logic         valid = 1'b0;
  logic [7:0]   pad_out;
  logic         ready, busy, done;
  logic [127:0] attr_o;
  wire  [7:0]   pad_io;
  logic         drv_en = 1'b0, drv_val = 1'b0;

  logic [4:0]   pad_in_s = '0, pad_oe_s = '0, mask_s = '0;
  logic [15:0]  attr_s = '0;
  logic         valid_s = 1'b0;
  logic [4:0]   pad_out_s;
  logic         ready_s, busy_s, done_s;
  logic [79:0]  attr_o_s;
  wire  [4:0]   pad_io_s;

  int total = 0;
  int bad = 0;

  assign pad_io[3] = drv_en ? drv_val : 1'bz;

  always #5 clk = ~clk;

  tsmc16_pad_bank_output_seq u_dut (
    .clk_i(clk), .rst_ni(rst_n), .pad_in_i(pad_in), .pad_oe_i(pad_oe),
    .pad_out_o(pad_out), .pad_io(pad_io), .attr_valid_i(valid),
    .attr_ready_o(ready), .attr_i(attr), .attr_mask_i(mask),
    .busy_o(busy), .done_o(done), .attr_o(attr_o)
  );

  tsmc16_pad_bank_output_seq #(.NUM_PADS(5), .GROUP_SIZE(2), .SETTLE_CYCLES(0)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .pad_in_i(pad_in_s), .pad_oe_i(pad_oe_s),
    .pad_out_o(pad_out_s), .pad_io(pad_io_s), .attr_valid_i(valid_s),
    .attr_ready_o(ready_s), .attr_i(attr_s), .attr_mask_i(mask_s),
    .busy_o(busy_s), .done_o(done_s), .attr_o(attr_o_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    valid_s = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (attr_o[k*16 +: 16] !== 16'h0034) begin
        bad++; $display("FAIL reset_attr pad%0d got=%h exp=0034", k, attr_o[k*16 +: 16]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (attr_o_s[k*16 +: 16] !== 16'h0034) begin
        bad++; $display("FAIL reset_attr_small pad%0d got=%h exp=0034", k, attr_o_s[k*16 +: 16]);
      end
    end
    total++;
    if ({ready, busy, done} !== 3'b100) begin
      bad++; $display("FAIL reset_flags got rdy/busy/done=%b exp=100", {ready, busy, done});
    end
    total++;
    if ({ready_s, busy_s, done_s} !== 3'b100) begin
      bad++; $display("FAIL reset_flags_small got=%b exp=100", {ready_s, busy_s, done_s});
    end
  endtask

  task automatic test_datapath();
    logic [3:0] vec [4];
    vec[0] = 4'b1_1_1_0; // {oe, in, exp_pad, ext_drive}
    vec[1] = 4'b1_0_0_0;
    vec[2] = 4'b0_0_1_1;
    vec[3] = 4'b0_1_0_1;
    for (int i = 0; i < 4; i++) begin
      drv_en  = 1'b0;
      pad_oe[3] = vec[i][3];
      pad_in[3] = vec[i][2];
      drv_val = vec[i][1];
      drv_en  = vec[i][0];
      #1;
      if (!vec[i][0]) begin
        total++;
        if (pad_io[3] !== vec[i][1]) begin
          bad++; $display("FAIL datapath_pad vec%0d got=%b exp=%b", i, pad_io[3], vec[i][1]);
        end
      end
      total++;
      if (pad_out[3] !== vec[i][1]) begin
        bad++; $display("FAIL datapath_c vec%0d got=%b exp=%b", i, pad_out[3], vec[i][1]);
      end
    end
    drv_en = 1'b0;
    pad_oe = '0;
    pad_in = '0;
  endtask

  task automatic test_full_seq();
    logic [15:0] exp;
    do_reset();
    attr = 16'h00F1; mask = 8'hFF; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int n = 1; n <= 23; n++) begin
      for (int k = 0; k < 8; k++) begin
        exp = (n >= 2 + 5 * (k / 2)) ? 16'h00F1 : 16'h0034;
        total++;
        if (attr_o[k*16 +: 16] !== exp) begin
          bad++; $display("FAIL full_attr T+%0d pad%0d got=%h exp=%h", n, k, attr_o[k*16 +: 16], exp);
        end
      end
      total++;
      if ({done, ready, busy} !== {n == 21, n >= 22, n <= 21}) begin
        bad++; $display("FAIL full_flags T+%0d got done/rdy/busy=%b exp=%b", n,
                        {done, ready, busy}, {n == 21, n >= 22, n <= 21});
      end
      tick();
    end
  endtask

  task automatic test_sparse();
    logic [15:0] exp;
    do_reset();
    attr = 16'h0A5C; mask = 8'h01; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      for (int k = 0; k < 8; k++) begin
        exp = (k == 0 && n >= 2) ? 16'h0A5C : 16'h0034;
        total++;
        if (attr_o[k*16 +: 16] !== exp) begin
          bad++; $display("FAIL sparse_attr T+%0d pad%0d got=%h exp=%h", n, k, attr_o[k*16 +: 16], exp);
        end
      end
      total++;
      if ({done, ready, busy} !== {n == 9, n >= 10, n <= 9}) begin
        bad++; $display("FAIL sparse_flags T+%0d got done/rdy/busy=%b exp=%b", n,
                        {done, ready, busy}, {n == 9, n >= 10, n <= 9});
      end
      tick();
    end
  endtask

  task automatic test_partial_group();
    logic [15:0] exp;
    do_reset();
    attr_s = 16'h1234; mask_s = 5'h1F; valid_s = 1'b1;
    tick();
    valid_s = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      for (int k = 0; k < 5; k++) begin
        exp = (n >= 2 + k / 2) ? 16'h1234 : 16'h0034;
        total++;
        if (attr_o_s[k*16 +: 16] !== exp) begin
          bad++; $display("FAIL partial_attr T+%0d pad%0d got=%h exp=%h", n, k, attr_o_s[k*16 +: 16], exp);
        end
      end
      total++;
      if ({done_s, ready_s} !== {n == 4, n >= 5}) begin
        bad++; $display("FAIL partial_flags T+%0d got done/rdy=%b exp=%b", n,
                        {done_s, ready_s}, {n == 4, n >= 5});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    do_reset();
    attr = 16'h0011; mask = 8'hFF; valid = 1'b1;
    tick();
    attr = 16'h0022; mask = 8'h0F;
    // Second request accepted at T+22; its group 0 lands at T+24, group 1 at T+29.
    for (int n = 1; n <= 36; n++) begin
      if (n == 23) valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (n <= 23) exp = (n >= 2 + 5 * (k / 2)) ? 16'h0011 : 16'h0034;
        else if (k < 2 || (k < 4 && n >= 29)) exp = 16'h0022;
        else exp = 16'h0011;
        total++;
        if (attr_o[k*16 +: 16] !== exp) begin
          bad++; $display("FAIL b2b_attr T+%0d pad%0d got=%h exp=%h", n, k, attr_o[k*16 +: 16], exp);
        end
      end
      total++;
      if ({ready, done} !== {n == 22 || n >= 36, n == 21 || n == 35}) begin
        bad++; $display("FAIL b2b_flags T+%0d got rdy/done=%b exp=%b", n,
                        {ready, done}, {n == 22 || n >= 36, n == 21 || n == 35});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    attr = 16'h00F1; mask = 8'hFF; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int n = 1; n < 8; n++) tick();
    total++;
    if (attr_o[31:0] !== 32'h00F1_00F1 || attr_o[47:32] !== 16'h00F1) begin
      bad++; $display("FAIL mid_pre pads0..2 got=%h exp=00f100f100f1", attr_o[47:0]);
    end
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (attr_o[k*16 +: 16] !== 16'h0034) begin
        bad++; $display("FAIL mid_attr pad%0d got=%h exp=0034", k, attr_o[k*16 +: 16]);
      end
    end
    total++;
    if ({ready, busy, done} !== 3'b100) begin
      bad++; $display("FAIL mid_flags got rdy/busy/done=%b exp=100", {ready, busy, done});
    end
    rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      tick();
      total++;
      if ({ready, done} !== 2'b10) begin
        bad++; $display("FAIL mid_idle cyc%0d got rdy/done=%b exp=10", n, {ready, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_datapath();
    test_full_seq();
    test_sparse();
    test_partial_group();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tsmc16_pad_bank_output_seq.md
# tsmc16_pad_bank_output_seq

Parametrised bank of NUM_PADS TSMC16 output pads with per-pad output enable and a sequenced pad-attribute update engine. A new attribute word reaches the pads one group of GROUP_SIZE pads at a time, with SETTLE_CYCLES idle cycles after each group. This limits simultaneous-switching noise when drive strength or pulls change at runtime. The block sits in the pad ring between the pad-control register file and the physical pads, and replaces per-pad output cells that had fixed attributes and OEN tied low.

## Interface
- NUM_PADS, 8: number of pads in the bank (>=1).
- PADATTR, 16: attribute word width (>=8). Bit mapping: [0]=PU, [1]=PD, [2]=IE, [3]=ST, [7:4]=DS0..DS3.
- GROUP_SIZE, 2: pads updated per step (1..NUM_PADS). NUM_GROUPS=ceil(NUM_PADS/GROUP_SIZE); the last group may be partial.
- SETTLE_CYCLES, 4: idle cycles after each active group (0..255; 0 means no settle state).
- RESET_ATTR, 16'h0034: attribute value of every pad after reset (IE=1, DS0=1, DS1=1).
- SIDE, core_v_mini_mcu_pkg::TOP: TOP/BOTTOM instantiate PDDWUWSWCDGS_H; LEFT/RIGHT instantiate PDDWUWSWCDGS_V.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- pad_in_i  in  NUM_PADS  data to pad I, combinational.
- pad_oe_i  in  NUM_PADS  output enable; drives OEN=~pad_oe_i[k], combinational. RTE is tied 0.
- pad_out_o  out  NUM_PADS  pad C readback, combinational.
- pad_io  inout  NUM_PADS  physical pads.
- attr_valid_i  in  1  update request.
- attr_ready_o  out  1  engine idle and able to accept a request.
- attr_i  in  PADATTR  new attribute word.
- attr_mask_i  in  NUM_PADS  pads that receive attr_i; unmasked pads keep their value.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse at sequence end.
- attr_o  out  NUM_PADS*PADATTR  current registered attributes; pad k occupies [k*PADATTR +: PADATTR].

## Operation
- State machine: IDLE, APPLY, SETTLE, DONE. A group counter g and a settle counter s run alongside it.
- IDLE: attr_ready_o=1. On attr_valid_i&&attr_ready_o, capture attr_i and attr_mask_i, set g=0, go to APPLY.
- APPLY (one cycle per group):
  - Group g is active if any mask bit in pads [g*GROUP_SIZE, min((g+1)*GROUP_SIZE, NUM_PADS)) is set.
  - Active group: at the clock edge ending the cycle, the attribute registers of the masked pads in the group load the captured word. Then go to SETTLE with s=0, or straight to the next step if SETTLE_CYCLES=0.
  - Inactive group: no write and no settle.
  - Next step: g+1 in APPLY, or DONE if g==NUM_GROUPS-1.
- SETTLE: s increments each cycle. After SETTLE_CYCLES cycles, take the next step as in APPLY.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in APPLY, SETTLE and DONE.
- Pads read their attribute registers directly. Bits above [7] are stored and reported on attr_o, but are not connected to the pad.
- A request with an all-zero mask is still accepted. It walks all groups as inactive and pulses done_o.
- attr_valid_i while busy: ignored, since attr_ready_o=0. The requester holds valid and data until the handshake.
- Captured attr/mask are stable for the whole sequence; attr_i changes during the sequence have no effect.

## Timing
- Reset (rst_ni=0 at a clock edge): state IDLE, g=s=0, every attr_o entry = RESET_ATTR, attr_ready_o=1, busy_o=0, done_o=0.
- Reset mid-sequence: the sequence is abandoned. Already-updated pads revert to RESET_ATTR and no done_o is produced.
- Handshake at the edge ending cycle T:
  - APPLY g0 runs in cycle T+1 and the new attributes are visible in T+2.
  - Each active group takes 1+SETTLE_CYCLES cycles; each inactive group takes 1 cycle.
  - done_o is high in the cycle after the last step. attr_ready_o is high the following cycle.
- All-active latency, handshake to done_o: NUM_GROUPS*(1+SETTLE_CYCLES)+1 cycles.
- The data path (pad_in_i→I, pad_oe_i→OEN, C→pad_out_o) has zero latency and is unaffected by the engine.

## Test plan
- Reset then idle: every attr_o entry = 0x0034, attr_ready_o=1, busy_o=0. Toggling pad_oe_i[3] and pad_in_i[3] follows on pad_io[3] in the same cycle; with oe=0 the pad floats.
- Defaults, mask=0xFF, attr=0x00F1, handshake at T:
  - Group 0 visible at T+2, group 1 at T+7, group 2 at T+12, group 3 at T+17.
  - done_o at T+21, attr_ready_o at T+22.
  - No group changes before its slot.
- mask=0x01: only pad 0 changes, visible at T+2. Groups 1–3 are skipped at T+6..T+8, done_o at T+9, pads 1–7 stay 0x0034.
- NUM_PADS=5, GROUP_SIZE=2, SETTLE_CYCLES=0, mask=0x1F: updates are visible at T+2, T+3, T+4 (the partial group is pad 4), and done_o is at T+4.
- attr_valid_i held high with new data during a sequence: the second request is accepted exactly at the attr_ready_o cycle, and the in-flight values are unchanged.
- rst_ni low at T+8 of a full-mask sequence: at the next edge, all attr_o entries = 0x0034, IDLE, no done_o.
